mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Elastic MEM->WB pipeline stage: carries the GPR write request (dest, enable, data)
//  and, optionally, the HI/LO write request from MEM to WB.
//  2-entry skid buffer with valid/ready handshake on both sides and synchronous flush.
//  Saturating back-pressure counter for performance monitoring.
//  Replaces the fixed single-register MEM/WB latch; every payload field is sized by
//  parameter.
// PARAMETERS
//  DATA_W            32  width of wdata, hi, lo
//  RADDR_W            5  width of GPR destination index
//  CNT_W             16  width of stall_cnt
//  ZERO_REG_SUPPRESS  1  1: a write to GPR index 0 leaves WB with wb_wreg=0
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst         in   1        synchronous, active-high reset
//  flush       in   1        sync flush; drops all held entries
//  in_valid    in   1        MEM presents a valid payload
//  in_ready    out  1        stage accepts the payload this cycle
//  mem_wd      in   RADDR_W  GPR destination
//  mem_wreg    in   1        GPR write enable
//  mem_wdata   in   DATA_W   GPR write data
//  mem_whilo   in   1        HI/LO write enable     [MEM_WB_HILO_EN only]
//  mem_hi      in   DATA_W   HI data                [MEM_WB_HILO_EN only]
//  mem_lo      in   DATA_W   LO data                [MEM_WB_HILO_EN only]
//  out_valid   out  1        WB payload valid
//  out_ready   in   1        WB consumes the payload this cycle
//  wb_wd       out  RADDR_W  registered GPR destination
//  wb_wreg     out  1        GPR write enable, qualified by out_valid
//  wb_wdata    out  DATA_W   GPR write data
//  wb_whilo    out  1        HI/LO enable, qualified by out_valid [MEM_WB_HILO_EN only]
//  wb_hi       out  DATA_W   HI data                [MEM_WB_HILO_EN only]
//  wb_lo       out  DATA_W   LO data                [MEM_WB_HILO_EN only]
//  stall_cnt   out  CNT_W    cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Storage: main entry (drives wb_*) and skid entry. States: EMPTY, ONE, TWO.
//  - acc = in_valid & in_ready;  dep = out_valid & out_ready.
//  - in_ready = !rst & (state!=TWO). out_valid = (state!=EMPTY). Both are
//    combinational from registered state only. No in->out combinational path.
//  - Transitions:
//      EMPTY:  acc -> ONE; main<=in.
//      ONE:    acc&!dep -> TWO, skid<=in.  acc&dep -> ONE, main<=in.
//              !acc&dep -> EMPTY.  Otherwise hold.
//      TWO:    dep -> ONE, main<=skid.  Otherwise hold.
//  - Latency: an accepted payload appears on wb_* the next cycle (1-cycle latency).
//  - Throughput: 1 payload/cycle while out_ready=1.
//  - Order is strictly FIFO. No payload is dropped or duplicated except by flush or rst.
//  - Qualified enables:
//      wb_wreg  = out_valid & main.wreg & !(ZERO_REG_SUPPRESS & main.wd==0).
//      wb_whilo = out_valid & main.whilo.
//  - Data fields hold their last value when invalid. Consumers must qualify with the
//    enables.
//  - flush=1 -> next state EMPTY. A payload accepted in the flush cycle is discarded.
//    flush has priority over acc and dep. stall_cnt is not affected.
//  - stall_cnt: +1 per cycle with out_valid & !out_ready; holds at 2^CNT_W-1.
//    The cycle counts even if flush is asserted in it.
//  - rst (highest priority): state EMPTY; all wb_* = 0; stall_cnt = 0.
//    in_ready = 0 while rst=1; out_valid = 0.
//  - rst mid-transfer: all held entries are discarded, same as flush.
// CONFIGURATION
//  MEM_WB_HILO_EN defined:
//    mem_whilo/hi/lo and wb_whilo/hi/lo exist.
//    The payload is {wd, wreg, wdata, whilo, hi, lo} with the same skid/flush rules.
//  MEM_WB_HILO_EN undefined:
//    Those six ports are absent.
//    The payload is {wd, wreg, wdata}. No HI/LO storage is built.
// TESTING
//  1. rst=1 for 2 cycles -> wb_*=0, out_valid=0, in_ready=0, stall_cnt=0.
//     Release rst -> in_ready=1.
//  2. Streaming: out_ready=1; push wd=3, wdata=0x11..0x14 on 4 back-to-back cycles
//     -> wb_wdata = 0x11..0x14 on cycles +1..+4 with wb_wreg=1; stall_cnt stays 0.
//  3. Back-pressure: push A=0xA, B=0xB with out_ready=0 -> in_ready=0 after B;
//     stall_cnt=2 after 2 cycles.
//     Raise out_ready -> A, then B, on consecutive cycles; in_ready=1 after A departs.
//  4. Flush: state TWO; flush=1 and in_valid=1 (C=0xC) in the same cycle
//     -> next cycle out_valid=0; C never appears on wb_*.
//  5. Zero register: wd=0, wreg=1, wdata=0xDEAD -> wb_wreg=0, out_valid=1.
//  6. Saturation and HI/LO: CNT_W=4 with 20 stall cycles -> stall_cnt=15.
//     With MEM_WB_HILO_EN, whilo=1, hi=0x1234, lo=0x5678
//     -> wb_whilo=1, wb_hi=0x1234, wb_lo=0x5678 one cycle later.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: elastic MEM->WB pipeline stage.
// Carries the GPR write request (and optionally the HI/LO write request) from
// MEM to WB through a 2-entry skid buffer with valid/ready on both sides,
// a synchronous flush and a saturating back-pressure counter.
// Optional feature macro: MEM_WB_HILO_EN adds the HI/LO ports and storage.
module mem_wb_pipe #(
    parameter int DATA_W            = 32,
    parameter int RADDR_W           = 5,
    parameter int CNT_W             = 16,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
`ifdef MEM_WB_HILO_EN
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
`ifdef MEM_WB_HILO_EN
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
`endif
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
`ifdef MEM_WB_HILO_EN
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
`endif
    } payload_t;

    state_e             state_q, state_d;
    payload_t           main_q, main_d;
    payload_t           skid_q, skid_d;
    payload_t           in_pld;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               acc, dep;
    logic               zero_hit;

    // Gather the incoming request fields into one payload word.
    always_comb begin
        in_pld       = '0;
        in_pld.wd    = mem_wd;
        in_pld.wreg  = mem_wreg;
        in_pld.wdata = mem_wdata;
`ifdef MEM_WB_HILO_EN
        in_pld.whilo = mem_whilo;
        in_pld.hi    = mem_hi;
        in_pld.lo    = mem_lo;
`endif
    end

    // Handshake flags depend only on registered state (and rst), never on the
    // opposite side's inputs, so no combinational path crosses the stage.
    assign in_ready  = !rst && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign dep       = out_valid && out_ready;

    // Next-state and entry-movement logic of the skid buffer; flush wins over
    // any accept/depart in the same cycle.
    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path
        // leaves it unassigned (which would infer a latch); blocking '=' is
        // correct here because this is combinational logic.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_pld;
                    end
                end
                ONE: begin
                    if (acc && !dep) begin
                        state_d = TWO;
                        skid_d  = in_pld;
                    end else if (acc && dep) begin
                        main_d  = in_pld;
                    end else if (dep) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (dep) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where WB holds off a valid payload; flush
    // does not stop the count for the cycle it is asserted in.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Control state, the WB-facing entry and the counter, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking '<=' so
        // every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Skid entry: only ever read after being written in the TWO state.
    always_ff @(posedge clk) begin
        // NOTE: this data-only entry is deliberately left without reset; its
        // contents are never observed until a write qualifies them.
        skid_q <= skid_d;
    end

    // Write enables are qualified by out_valid; a GPR write to index 0 is
    // suppressed when ZERO_REG_SUPPRESS is set.
    assign zero_hit  = (ZERO_REG_SUPPRESS != 0) && (main_q.wd == '0);
    assign wb_wd     = main_q.wd;
    assign wb_wdata  = main_q.wdata;
    assign wb_wreg   = out_valid && main_q.wreg && !zero_hit;
`ifdef MEM_WB_HILO_EN
    assign wb_whilo  = out_valid && main_q.whilo;
    assign wb_hi     = main_q.hi;
    assign wb_lo     = main_q.lo;
`endif
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed, scoreboard-checked bench for mem_wb_pipe.
// Builds with or without MEM_WB_HILO_EN; the counter is instantiated 4 bits
// wide so saturation is reachable in a short run.
module tb_mem_wb_pipe;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] mem_wd;
    logic               mem_wreg;
    logic [DATA_W-1:0]  mem_wdata;
    logic               out_valid;
    logic               out_ready;
    logic [RADDR_W-1:0] wb_wd;
    logic               wb_wreg;
    logic [DATA_W-1:0]  wb_wdata;
    logic [CNT_W-1:0]   stall_cnt;
`ifdef MEM_WB_HILO_EN
    logic               mem_whilo;
    logic [DATA_W-1:0]  mem_hi;
    logic [DATA_W-1:0]  mem_lo;
    logic               wb_whilo;
    logic [DATA_W-1:0]  wb_hi;
    logic [DATA_W-1:0]  wb_lo;
`endif

    typedef struct {
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
`ifdef MEM_WB_HILO_EN
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
`endif
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_wb_pipe #(
        .DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W), .ZERO_REG_SUPPRESS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
`ifdef MEM_WB_HILO_EN
        .mem_whilo (mem_whilo),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
`ifdef MEM_WB_HILO_EN
        .wb_whilo  (wb_whilo),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
`endif
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [RADDR_W-1:0] wd, input logic wreg,
                        input logic [DATA_W-1:0] wdata);
        in_valid  = 1'b1;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
        tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: departures are compared against the oldest accepted payload;
    // accepted payloads are queued; flush/rst drop everything held.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty_on_depart", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_wd",    64'(wb_wd),    64'(e.wd));
                check("sb_wreg",  64'(wb_wreg),  64'(e.wreg));
                check("sb_wdata", 64'(wb_wdata), 64'(e.wdata));
`ifdef MEM_WB_HILO_EN
                check("sb_whilo", 64'(wb_whilo), 64'(e.whilo));
                check("sb_hi",    64'(wb_hi),    64'(e.hi));
                check("sb_lo",    64'(wb_lo),    64'(e.lo));
`endif
            end
        end
        if (rst || flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            e.wd    = mem_wd;
            e.wreg  = mem_wreg && (mem_wd != '0);
            e.wdata = mem_wdata;
`ifdef MEM_WB_HILO_EN
            e.whilo = mem_whilo;
            e.hi    = mem_hi;
            e.lo    = mem_lo;
`endif
            sb_q.push_back(e);
        end
    end

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
`ifdef MEM_WB_HILO_EN
        mem_whilo = 1'b0;
        mem_hi    = '0;
        mem_lo    = '0;
`endif

        // Reset for two cycles.
        tick();
        tick();
        check("rst_wb_wd",     64'(wb_wd),     64'd0);
        check("rst_wb_wreg",   64'(wb_wreg),   64'd0);
        check("rst_wb_wdata",  64'(wb_wdata),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming: one payload per cycle, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(5'd3, 1'b1, 32'h11 + 32'(i));
            check("stream_out_valid", 64'(out_valid), 64'd1);
            check("stream_wb_wdata",  64'(wb_wdata),  64'h11 + 64'(i));
            check("stream_wb_wreg",   64'(wb_wreg),   64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained",   64'(out_valid), 64'd0);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure: fill both entries, then release.
        reset_pulse();
        out_ready = 1'b0;
        push(5'd5, 1'b1, 32'hA);
        check("bp_in_ready_one", 64'(in_ready), 64'd1);
        push(5'd5, 1'b1, 32'hB);
        in_valid = 1'b0;
        check("bp_in_ready_full", 64'(in_ready),  64'd0);
        check("bp_head_is_a",     64'(wb_wdata),  64'hA);
        check("bp_stall_1",       64'(stall_cnt), 64'd1);
        tick();
        check("bp_stall_2",       64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        check("bp_head_is_b",     64'(wb_wdata),  64'hB);
        check("bp_in_ready_back", 64'(in_ready),  64'd1);
        check("bp_valid_b",       64'(out_valid), 64'd1);
        tick();
        check("bp_drained",       64'(out_valid), 64'd0);
        check("bp_stall_hold",    64'(stall_cnt), 64'd2);

        // Flush from TWO with a payload offered, then from ONE with it accepted.
        reset_pulse();
        out_ready = 1'b0;
        push(5'd4, 1'b1, 32'h21);
        push(5'd4, 1'b1, 32'h22);
        flush     = 1'b1;
        mem_wdata = 32'hC;
        tick();
        check("flush2_out_valid", 64'(out_valid), 64'd0);
        check("flush2_in_ready",  64'(in_ready),  64'd1);
        check("flush2_stall_cnt", 64'(stall_cnt), 64'd2);
        flush = 1'b0;
        push(5'd4, 1'b1, 32'h31);
        flush     = 1'b1;
        mem_wdata = 32'hC;
        tick();
        check("flush1_out_valid", 64'(out_valid), 64'd0);
        check("flush1_stall_cnt", 64'(stall_cnt), 64'd3);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("flush_c_absent", 64'(out_valid), 64'd0);

        // Zero-register suppression and enable qualification.
        reset_pulse();
        out_ready = 1'b1;
        push(5'd0, 1'b1, 32'hDEAD);
        in_valid = 1'b0;
        check("zero_out_valid", 64'(out_valid), 64'd1);
        check("zero_wb_wreg",   64'(wb_wreg),   64'd0);
        check("zero_wb_wdata",  64'(wb_wdata),  64'hDEAD);
        push(5'd7, 1'b0, 32'h77);
        check("nowreg_wb_wreg", 64'(wb_wreg), 64'd0);
        push(5'd7, 1'b1, 32'h78);
        in_valid = 1'b0;
        check("wreg7_wb_wreg", 64'(wb_wreg), 64'd1);
        check("wreg7_wb_wd",   64'(wb_wd),   64'd7);
        tick();

        // HI/LO payload and counter saturation.
        reset_pulse();
        out_ready = 1'b0;
`ifdef MEM_WB_HILO_EN
        mem_whilo = 1'b1;
        mem_hi    = 32'h1234;
        mem_lo    = 32'h5678;
`endif
        push(5'd9, 1'b1, 32'h55);
        in_valid = 1'b0;
`ifdef MEM_WB_HILO_EN
        mem_whilo = 1'b0;
        mem_hi    = '0;
        mem_lo    = '0;
        check("hilo_wb_whilo", 64'(wb_whilo), 64'd1);
        check("hilo_wb_hi",    64'(wb_hi),    64'h1234);
        check("hilo_wb_lo",    64'(wb_lo),    64'h5678);
`endif
        repeat (14) tick();
        check("sat_stall_14", 64'(stall_cnt), 64'd14);
        tick();
        check("sat_stall_15", 64'(stall_cnt), 64'd15);
        repeat (5) tick();
        check("sat_stall_hold", 64'(stall_cnt), 64'd15);
        out_ready = 1'b1;
        tick();
        check("sat_drained",     64'(out_valid), 64'd0);
        check("sat_stall_final", 64'(stall_cnt), 64'd15);

        check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
